// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: branch/ALU/forward codes and the decoded
// control bundle carried from ID through the stage registers.
package cpu_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_BGTZ = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Full decoder bundle as seen in ID.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       ext_op;
    logic [1:0] branch;
    logic [2:0] alu_op;
  } ctrl_t;

  // Stage subsets: each register keeps only what later stages consume.
  typedef struct packed {
    logic       alu_src;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] branch;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  // rt is a source for R-type, stores and the two-register branches.
  function automatic logic uses_rt(input ctrl_t c);
    return c.reg_dst | c.mem_write | (c.branch == BR_BEQ) | (c.branch == BR_BNE);
  endfunction

  function automatic ex_ctrl_t to_ex(input ctrl_t c);
    ex_ctrl_t e;
    e.alu_src    = c.alu_src;
    e.ext_op     = c.ext_op;
    e.alu_op     = c.alu_op;
    e.mem_to_reg = c.mem_to_reg;
    e.reg_write  = c.reg_write;
    e.mem_write  = c.mem_write;
    e.branch     = c.branch;
    return e;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Priority forwarding select for one EX source operand: MEM beats WB,
// and register $0 never forwards.
module fwd_unit
  import cpu_pkg::*;
(
  input  logic       src_valid,
  input  logic [4:0] src,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_waddr,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_waddr,
  output logic [1:0] fwd
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write & (mem_waddr != 5'd0) & (mem_waddr == src);
  assign wb_hit  = wb_reg_write  & (wb_waddr  != 5'd0) & (wb_waddr  == src);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fwd = FWD_RF;
    if (src_valid) begin
      if (mem_hit)     fwd = FWD_MEM;
      else if (wb_hit) fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Control-side pipeline: carries the decoded bundle through ID/EX, EX/MEM and
// MEM/WB, and produces load-use stall, EX branch resolution and forward selects.
module control_pipe
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic       id_RegDst,
  input  logic       id_ALUSrc,
  input  logic       id_MemtoReg,
  input  logic       id_RegWrite,
  input  logic       id_MemWrite,
  input  logic       id_ExtOp,
  input  logic [1:0] id_Branch,
  input  logic [2:0] id_ALUop,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_zero,
  input  logic       ex_neg,
  output logic       stall,
  output logic       branch_taken,
  output logic       ex_ALUSrc,
  output logic       ex_ExtOp,
  output logic [2:0] ex_ALUop,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_MemWrite,
  output logic       mem_MemtoReg,
  output logic       wb_RegWrite,
  output logic       wb_MemtoReg,
  output logic [4:0] wb_waddr
);

  ctrl_t id_ctrl;

  logic      ex_valid_q;
  ex_ctrl_t  ex_ctrl_q;
  logic [4:0] ex_rs_q, ex_rt_q, ex_waddr_q;

  logic      mem_valid_q;
  mem_ctrl_t mem_ctrl_q;
  logic [4:0] mem_waddr_q;

  logic      wb_valid_q;
  wb_ctrl_t  wb_ctrl_q;
  logic [4:0] wb_waddr_q;

  logic branch_cond;
  logic load_use;
  logic bubble;

  always_comb begin
    id_ctrl.reg_dst    = id_RegDst;
    id_ctrl.alu_src    = id_ALUSrc;
    id_ctrl.mem_to_reg = id_MemtoReg;
    id_ctrl.reg_write  = id_RegWrite;
    id_ctrl.mem_write  = id_MemWrite;
    id_ctrl.ext_op     = id_ExtOp;
    id_ctrl.branch     = id_Branch;
    id_ctrl.alu_op     = id_ALUop;
  end

  always_comb begin
    branch_cond = 1'b0;
    case (ex_ctrl_q.branch)
      BR_BEQ:  branch_cond = ex_zero;
      BR_BNE:  branch_cond = ~ex_zero;
      BR_BGTZ: branch_cond = ~ex_zero & ~ex_neg;
      default: branch_cond = 1'b0;
    endcase
  end

  assign branch_taken = ex_valid_q & branch_cond;

  assign load_use = id_valid & ex_valid_q & ex_ctrl_q.mem_to_reg & (ex_waddr_q != 5'd0) &
                    ((ex_waddr_q == id_rs) | (uses_rt(id_ctrl) & (ex_waddr_q == id_rt)));

  // A branch in EX cannot also be a load, but if both fire the redirect wins.
  assign stall  = load_use & ~branch_taken;
  assign bubble = stall | branch_taken | ~id_valid;

  // NOTE: stage registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_waddr_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_waddr_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_waddr_q  <= '0;
    end else begin
      if (bubble) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= '0;
        ex_rs_q    <= '0;
        ex_rt_q    <= '0;
        ex_waddr_q <= '0;
      end else begin
        ex_valid_q <= 1'b1;
        ex_ctrl_q  <= to_ex(id_ctrl);
        ex_rs_q    <= id_rs;
        ex_rt_q    <= id_rt;
        ex_waddr_q <= id_RegDst ? id_rd : id_rt;
      end

      mem_valid_q           <= ex_valid_q;
      mem_ctrl_q.mem_to_reg <= ex_ctrl_q.mem_to_reg;
      mem_ctrl_q.reg_write  <= ex_ctrl_q.reg_write;
      mem_ctrl_q.mem_write  <= ex_ctrl_q.mem_write;
      mem_waddr_q           <= ex_waddr_q;

      wb_valid_q           <= mem_valid_q;
      wb_ctrl_q.mem_to_reg <= mem_ctrl_q.mem_to_reg;
      wb_ctrl_q.reg_write  <= mem_ctrl_q.reg_write;
      wb_waddr_q           <= mem_waddr_q;
    end
  end

  fwd_unit u_fwd_a (
    .src_valid     (ex_valid_q),
    .src           (ex_rs_q),
    .mem_reg_write (mem_valid_q & mem_ctrl_q.reg_write),
    .mem_waddr     (mem_waddr_q),
    .wb_reg_write  (wb_valid_q & wb_ctrl_q.reg_write),
    .wb_waddr      (wb_waddr_q),
    .fwd           (fwd_a)
  );

  fwd_unit u_fwd_b (
    .src_valid     (ex_valid_q),
    .src           (ex_rt_q),
    .mem_reg_write (mem_valid_q & mem_ctrl_q.reg_write),
    .mem_waddr     (mem_waddr_q),
    .wb_reg_write  (wb_valid_q & wb_ctrl_q.reg_write),
    .wb_waddr      (wb_waddr_q),
    .fwd           (fwd_b)
  );

  assign ex_ALUSrc    = ex_valid_q & ex_ctrl_q.alu_src;
  assign ex_ExtOp     = ex_valid_q & ex_ctrl_q.ext_op;
  assign ex_ALUop     = ex_valid_q ? ex_ctrl_q.alu_op : 3'b000;
  assign mem_MemWrite = mem_valid_q & mem_ctrl_q.mem_write;
  assign mem_MemtoReg = mem_valid_q & mem_ctrl_q.mem_to_reg;
  assign wb_RegWrite  = wb_valid_q & wb_ctrl_q.reg_write & (wb_waddr_q != 5'd0);
  assign wb_MemtoReg  = wb_valid_q & wb_ctrl_q.mem_to_reg;
  assign wb_waddr     = wb_valid_q ? wb_waddr_q : 5'd0;

endmodule
